// File: rtl/ray_dispatch_sched.sv
// ray_dispatch_sched: frame-level scheduler for the ray-tracing pipeline.
// Hands ray IDs 0..N-1 round-robin to two traversal lanes under per-lane
// in-flight credit limits, forwards per-lane completions one cycle later and
// reports a frame cycle count once every issued ray has retired.
module ray_dispatch_sched #(
  parameter int unsigned ID_W         = 32,
  parameter int unsigned HIT_W        = 32,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic [ID_W-1:0]  io_num_rays,
  output logic             io_busy,
  output logic             io_lane0_valid,
  input  logic             io_lane0_ready,
  output logic [ID_W-1:0]  io_lane0_ray_id,
  output logic             io_lane1_valid,
  input  logic             io_lane1_ready,
  output logic [ID_W-1:0]  io_lane1_ray_id,
  input  logic             io_done0_valid,
  input  logic [ID_W-1:0]  io_done0_ray_id,
  input  logic [HIT_W-1:0] io_done0_hitT,
  input  logic             io_done1_valid,
  input  logic [ID_W-1:0]  io_done1_ray_id,
  input  logic [HIT_W-1:0] io_done1_hitT,
  output logic             io_res0_valid,
  output logic [ID_W-1:0]  io_res0_ray_id,
  output logic [HIT_W-1:0] io_res0_hitT,
  output logic             io_res1_valid,
  output logic [ID_W-1:0]  io_res1_ray_id,
  output logic [HIT_W-1:0] io_res1_hitT,
  output logic             io_rtp_finish,
  output logic [CNT_W-1:0] io_cycle_count,
  output logic             io_err
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StDispatch = 2'd1;
  localparam logic [1:0] StDrain    = 2'd2;
  localparam logic [1:0] StFinish   = 2'd3;

  localparam logic [7:0]       MaxInf = 8'(MAX_INFLIGHT);
  localparam logic [ID_W-1:0]  IdOne  = {{(ID_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CcOne  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CcMax  = {CNT_W{1'b1}};

  // State registers
  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_num_rays;
  logic [ID_W-1:0]  r_next_id;
  logic [ID_W-1:0]  r_issued;
  logic [ID_W-1:0]  r_retired;
  logic [7:0]       r_inflight0;
  logic [7:0]       r_inflight1;
  logic             r_rr;         // preferred lane for the next fresh offer
  logic             r_hold;       // an offer is pending and must not move
  logic             r_hold_lane;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_err;
  logic             r_res0_valid;
  logic [ID_W-1:0]  r_res0_ray_id;
  logic [HIT_W-1:0] r_res0_hitT;
  logic             r_res1_valid;
  logic [ID_W-1:0]  r_res1_ray_id;
  logic [HIT_W-1:0] r_res1_hitT;

  // Combinational signals
  logic             w_busy;
  logic             w_start_acc;
  logic             w_elig0;
  logic             w_elig1;
  logic             w_offer;
  logic             w_offer_lane;
  logic             w_valid0;
  logic             w_valid1;
  logic             w_fire0;
  logic             w_fire1;
  logic             w_fire;
  logic             w_dec0;
  logic             w_dec1;
  logic             w_under;
  logic [1:0]       w_done_cnt;
  logic [ID_W-1:0]  w_retired_base;
  logic [ID_W:0]    w_retired_sum;
  logic [ID_W-1:0]  w_num_eff;
  logic             w_over;
  logic             w_last_issue;
  logic [1:0]       w_state_d;
  logic [ID_W-1:0]  w_num_rays_d;
  logic [ID_W-1:0]  w_next_id_d;
  logic [ID_W-1:0]  w_issued_d;
  logic [ID_W-1:0]  w_retired_d;
  logic [7:0]       w_inflight0_d;
  logic [7:0]       w_inflight1_d;
  logic             w_rr_d;
  logic             w_hold_d;
  logic             w_hold_lane_d;
  logic [CNT_W-1:0] w_cycle_count_d;
  logic             w_err_d;

  assign w_busy      = (r_state == StDispatch) || (r_state == StDrain);
  // FINISH accepts a new frame exactly like IDLE
  assign w_start_acc = io_start && ((r_state == StIdle) || (r_state == StFinish));
  assign w_elig0     = r_inflight0 < MaxInf;
  assign w_elig1     = r_inflight1 < MaxInf;

  // Lane arbitration: a pending offer is locked, otherwise prefer rr lane then the other
  always_comb begin
    w_offer      = 1'b0;
    w_offer_lane = 1'b0;
    if (r_state == StDispatch) begin
      if (r_hold) begin
        w_offer      = 1'b1;
        w_offer_lane = r_hold_lane;
      end else if (r_rr ? w_elig1 : w_elig0) begin
        w_offer      = 1'b1;
        w_offer_lane = r_rr;
      end else if (r_rr ? w_elig0 : w_elig1) begin
        w_offer      = 1'b1;
        w_offer_lane = ~r_rr;
      end
    end
  end

  assign w_valid0 = w_offer && !w_offer_lane;
  assign w_valid1 = w_offer && w_offer_lane;
  assign w_fire0  = w_valid0 && io_lane0_ready;
  assign w_fire1  = w_valid1 && io_lane1_ready;
  assign w_fire   = w_fire0 || w_fire1;

  // A done on an empty lane is an error and must not wrap the credit counter
  assign w_dec0  = io_done0_valid && (r_inflight0 != 8'd0);
  assign w_dec1  = io_done1_valid && (r_inflight1 != 8'd0);
  assign w_under = (io_done0_valid && (r_inflight0 == 8'd0)) ||
                   (io_done1_valid && (r_inflight1 == 8'd0));

  assign w_done_cnt     = {1'b0, io_done0_valid} + {1'b0, io_done1_valid};
  assign w_retired_base = w_start_acc ? '0 : r_retired;
  assign w_retired_sum  = {1'b0, w_retired_base} + {{(ID_W-1){1'b0}}, w_done_cnt};
  assign w_num_eff      = w_start_acc ? io_num_rays : r_num_rays;
  assign w_over         = w_retired_sum > {1'b0, w_num_eff};
  assign w_last_issue   = (r_issued + IdOne) == r_num_rays;

  // Per-lane credit counters: issue and retire in the same cycle cancel out
  always_comb begin
    w_inflight0_d = r_inflight0;
    w_inflight1_d = r_inflight1;
    case ({w_fire0, w_dec0})
      2'b10:   w_inflight0_d = r_inflight0 + 8'd1;
      2'b01:   w_inflight0_d = r_inflight0 - 8'd1;
      default: w_inflight0_d = r_inflight0;
    endcase
    case ({w_fire1, w_dec1})
      2'b10:   w_inflight1_d = r_inflight1 + 8'd1;
      2'b01:   w_inflight1_d = r_inflight1 - 8'd1;
      default: w_inflight1_d = r_inflight1;
    endcase
  end

  // Frame FSM and issue bookkeeping
  always_comb begin
    w_state_d     = r_state;
    w_num_rays_d  = r_num_rays;
    w_next_id_d   = r_next_id;
    w_issued_d    = r_issued;
    w_retired_d   = w_retired_sum[ID_W-1:0];
    w_rr_d        = r_rr;
    w_hold_d      = 1'b0;
    w_hold_lane_d = r_hold_lane;
    case (r_state)
      StIdle, StFinish: begin
        if (w_start_acc) begin
          w_num_rays_d = io_num_rays;
          w_next_id_d  = '0;
          w_issued_d   = '0;
          w_rr_d       = 1'b0;
          w_state_d    = (io_num_rays == '0) ? StFinish : StDispatch;
        end
      end
      StDispatch: begin
        if (w_fire) begin
          w_next_id_d = r_next_id + IdOne;
          w_issued_d  = r_issued + IdOne;
          w_rr_d      = ~w_offer_lane;
          if (w_last_issue) begin
            w_state_d = StDrain;
          end
        end else if (w_offer) begin
          w_hold_d      = 1'b1;
          w_hold_lane_d = w_offer_lane;
        end
      end
      StDrain: begin
        if (r_retired == r_num_rays) begin
          w_state_d = StFinish;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Frame cycle counter: cleared on start, saturating while busy, frozen otherwise
  always_comb begin
    w_cycle_count_d = r_cycle_count;
    if (w_start_acc) begin
      w_cycle_count_d = '0;
    end else if (w_busy && (r_cycle_count != CcMax)) begin
      w_cycle_count_d = r_cycle_count + CcOne;
    end
  end

  assign w_err_d = r_err || w_under || w_over;

  // Control state registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StIdle;
      r_num_rays    <= '0;
      r_next_id     <= '0;
      r_issued      <= '0;
      r_retired     <= '0;
      r_inflight0   <= 8'd0;
      r_inflight1   <= 8'd0;
      r_rr          <= 1'b0;
      r_hold        <= 1'b0;
      r_hold_lane   <= 1'b0;
      r_cycle_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_num_rays    <= w_num_rays_d;
      r_next_id     <= w_next_id_d;
      r_issued      <= w_issued_d;
      r_retired     <= w_retired_d;
      r_inflight0   <= w_inflight0_d;
      r_inflight1   <= w_inflight1_d;
      r_rr          <= w_rr_d;
      r_hold        <= w_hold_d;
      r_hold_lane   <= w_hold_lane_d;
      r_cycle_count <= w_cycle_count_d;
      r_err         <= w_err_d;
    end
  end

  // One-cycle registered copy of each lane's completion
  always_ff @(posedge clock) begin
    if (reset) begin
      r_res0_valid  <= 1'b0;
      r_res0_ray_id <= '0;
      r_res0_hitT   <= '0;
      r_res1_valid  <= 1'b0;
      r_res1_ray_id <= '0;
      r_res1_hitT   <= '0;
    end else begin
      r_res0_valid  <= io_done0_valid;
      r_res0_ray_id <= io_done0_ray_id;
      r_res0_hitT   <= io_done0_hitT;
      r_res1_valid  <= io_done1_valid;
      r_res1_ray_id <= io_done1_ray_id;
      r_res1_hitT   <= io_done1_hitT;
    end
  end

  assign io_busy         = w_busy;
  assign io_rtp_finish   = (r_state == StFinish);
  assign io_lane0_valid  = w_valid0;
  assign io_lane0_ray_id = w_valid0 ? r_next_id : '0;
  assign io_lane1_valid  = w_valid1;
  assign io_lane1_ray_id = w_valid1 ? r_next_id : '0;
  assign io_res0_valid   = r_res0_valid;
  assign io_res0_ray_id  = r_res0_ray_id;
  assign io_res0_hitT    = r_res0_hitT;
  assign io_res1_valid   = r_res1_valid;
  assign io_res1_ray_id  = r_res1_ray_id;
  assign io_res1_hitT    = r_res1_hitT;
  assign io_cycle_count  = r_cycle_count;
  assign io_err          = r_err;

endmodule

// File: tb/tb_ray_dispatch_sched.sv
// Self-checking bench for ray_dispatch_sched: a per-cycle vector table for a
// short frame, directed corner-case sequences and a randomized run against a
// queue-based reference model of the scheduler.
module tb_ray_dispatch_sched;

  localparam int MAXI = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_rays;
  logic        busy;
  logic        v0, r0, v1, r1;
  logic [31:0] id0, id1;
  logic        d0, d1;
  logic [31:0] d0id, d0hit, d1id, d1hit;
  logic        rv0, rv1;
  logic [31:0] rid0, rhit0, rid1, rhit1;
  logic        fin;
  logic [31:0] cc;
  logic        err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  ray_dispatch_sched #(
    .ID_W(32), .HIT_W(32), .MAX_INFLIGHT(MAXI), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset),
    .io_start(start), .io_num_rays(num_rays), .io_busy(busy),
    .io_lane0_valid(v0), .io_lane0_ready(r0), .io_lane0_ray_id(id0),
    .io_lane1_valid(v1), .io_lane1_ready(r1), .io_lane1_ray_id(id1),
    .io_done0_valid(d0), .io_done0_ray_id(d0id), .io_done0_hitT(d0hit),
    .io_done1_valid(d1), .io_done1_ray_id(d1id), .io_done1_hitT(d1hit),
    .io_res0_valid(rv0), .io_res0_ray_id(rid0), .io_res0_hitT(rhit0),
    .io_res1_valid(rv1), .io_res1_ray_id(rid1), .io_res1_hitT(rhit1),
    .io_rtp_finish(fin), .io_cycle_count(cc), .io_err(err)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; num_rays = '0; r0 = 1'b0; r1 = 1'b0;
    d0 = 1'b0; d0id = '0; d0hit = '0;
    d1 = 1'b0; d1id = '0; d1hit = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_offer(input string name, input logic ev0, input logic [31:0] eid0,
                           input logic ev1, input logic [31:0] eid1);
    chk1({name, "_v0"}, v0, ev0);
    if (ev0) chk32({name, "_id0"}, id0, eid0);
    chk1({name, "_v1"}, v1, ev1);
    if (ev1) chk32({name, "_id1"}, id1, eid1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start;
    logic [31:0] num;
    logic        d0;
    logic [31:0] d0id;
    logic        d1;
    logic [31:0] d1id;
    logic        ev0;
    logic [31:0] eid0;
    logic        ev1;
    logic [31:0] eid1;
    logic        ebusy;
    logic        efin;
    logic [31:0] ecc;
    logic        erv0;
    logic        erv1;
  } vec_t;

  vec_t tbl[11];

  // ---------------- reference model ----------------
  int          m_mode;  // 0 idle, 1 dispatch, 2 drain, 3 finish
  int unsigned m_num, m_next, m_retired, m_cc;
  int          m_pref, m_lock, m_lock_lane;
  logic        m_err;
  int unsigned q0[$];
  int unsigned q1[$];
  logic        m_rv0, m_rv1;
  logic [31:0] m_rid0, m_rh0, m_rid1, m_rh1;

  task automatic m_reset();
    m_mode = 0; m_num = 0; m_next = 0; m_retired = 0; m_cc = 0;
    m_pref = 0; m_lock = 0; m_lock_lane = 0; m_err = 1'b0;
    q0.delete(); q1.delete();
    m_rv0 = 1'b0; m_rv1 = 1'b0;
    m_rid0 = '0; m_rh0 = '0; m_rid1 = '0; m_rh1 = '0;
  endtask

  function automatic int m_qsize(input int lane);
    return (lane == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int m_offer_lane();
    if (m_mode != 1) return -1;
    if (m_lock != 0) return m_lock_lane;
    if (m_qsize(m_pref) < MAXI) return m_pref;
    if (m_qsize(1 - m_pref) < MAXI) return 1 - m_pref;
    return -1;
  endfunction

  task automatic rand_cycle(input logic want_start, input logic [31:0] n);
    int          lane;
    int          nd;
    int          old_mode;
    int unsigned old_ret;
    logic        hs;
    logic        sok;
    lane = m_offer_lane();
    chk1("rnd_v0", v0, lane == 0);
    if (lane == 0) chk32("rnd_id0", id0, m_next);
    chk1("rnd_v1", v1, lane == 1);
    if (lane == 1) chk32("rnd_id1", id1, m_next);
    chk1("rnd_busy", busy, (m_mode == 1) || (m_mode == 2));
    chk1("rnd_fin", fin, m_mode == 3);
    chk32("rnd_cc", cc, m_cc);
    chk1("rnd_err", err, m_err);
    chk1("rnd_rv0", rv0, m_rv0);
    if (m_rv0) begin
      chk32("rnd_rid0", rid0, m_rid0);
      chk32("rnd_rhit0", rhit0, m_rh0);
    end
    chk1("rnd_rv1", rv1, m_rv1);
    if (m_rv1) begin
      chk32("rnd_rid1", rid1, m_rid1);
      chk32("rnd_rhit1", rhit1, m_rh1);
    end

    idle_in();
    start = want_start;
    num_rays = n;
    if (!want_start && (m_mode == 1 || m_mode == 2) && $urandom_range(0, 15) == 0) begin
      start = 1'b1;
      num_rays = $urandom_range(0, 50);
    end
    r0 = ($urandom_range(0, 3) != 0);
    r1 = ($urandom_range(0, 3) != 0);
    if (q0.size() > 0 && $urandom_range(0, 2) == 0) begin
      d0 = 1'b1;
      d0id = q0[0];
    end
    if (q1.size() > 0 && $urandom_range(0, 2) == 0) begin
      d1 = 1'b1;
      d1id = q1[0];
    end
    d0hit = $urandom;
    d1hit = $urandom;
    tick();

    hs       = (lane == 0 && r0) || (lane == 1 && r1);
    sok      = start && (m_mode == 0 || m_mode == 3);
    old_mode = m_mode;
    old_ret  = m_retired;
    nd       = int'(d0) + int'(d1);
    if (d0) begin
      if (q0.size() == 0) m_err = 1'b1;
      else void'(q0.pop_front());
    end
    if (d1) begin
      if (q1.size() == 0) m_err = 1'b1;
      else void'(q1.pop_front());
    end
    if ((old_mode == 1 || old_mode == 2) && m_cc != 32'hFFFF_FFFF) m_cc++;
    m_retired = sok ? nd : m_retired + nd;
    if (m_retired > (sok ? num_rays : m_num)) m_err = 1'b1;
    if (hs) begin
      if (lane == 0) q0.push_back(m_next);
      else q1.push_back(m_next);
      m_next++;
      m_pref = 1 - lane;
      m_lock = 0;
    end else if (lane >= 0) begin
      m_lock = 1;
      m_lock_lane = lane;
    end
    if (old_mode == 1 && hs && m_next == m_num) begin
      m_mode = 2;
    end else if (old_mode == 2 && old_ret == m_num) begin
      m_mode = 3;
    end else if (sok) begin
      m_num = num_rays; m_next = 0; m_cc = 0; m_pref = 0; m_lock = 0;
      m_mode = (num_rays == 0) ? 3 : 1;
    end
    m_rv0 = d0; m_rid0 = d0id; m_rh0 = d0hit;
    m_rv1 = d1; m_rid1 = d1id; m_rh1 = d1hit;
  endtask

  initial begin
    int          hs_cnt;
    int          cyc;
    logic [31:0] n;

    // start, num, d0, d0id, d1, d1id | ev0, eid0, ev1, eid1, busy, fin, cc, rv0, rv1
    tbl[0]  = '{1'b1, 32'd4, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b1, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b1, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0, 32'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 32'd0,
                1'b0, 32'd0, 1'b1, 32'd3, 1'b1, 1'b0, 32'd3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd1,
                1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd4, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'd0, 1'b1, 32'd2, 1'b0, 32'd0,
                1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd3,
                1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd6, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd7, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0,
                1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd8, 1'b0, 1'b0};

    // Table: 4-ray frame, both lanes always ready, dones 3 cycles after issue
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk_offer($sformatf("tbl%0d", i), tbl[i].ev0, tbl[i].eid0, tbl[i].ev1, tbl[i].eid1);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
      chk1($sformatf("tbl%0d_fin", i), fin, tbl[i].efin);
      chk32($sformatf("tbl%0d_cc", i), cc, tbl[i].ecc);
      chk1($sformatf("tbl%0d_rv0", i), rv0, tbl[i].erv0);
      chk1($sformatf("tbl%0d_rv1", i), rv1, tbl[i].erv1);
      chk1($sformatf("tbl%0d_err", i), err, 1'b0);
      start = tbl[i].start; num_rays = tbl[i].num; r0 = 1'b1; r1 = 1'b1;
      d0 = tbl[i].d0; d0id = tbl[i].d0id; d1 = tbl[i].d1; d1id = tbl[i].d1id;
      tick();
    end

    // Credit limit: 20 rays, no dones, only 2*MAXI may issue
    do_reset();
    start = 1'b1; num_rays = 32'd20; r0 = 1'b1; r1 = 1'b1;
    tick();
    start = 1'b0;
    hs_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if ((v0 && r0) || (v1 && r1)) hs_cnt++;
      tick();
    end
    chk32("credit_issued", hs_cnt, 32'd16);
    chk_offer("credit_full", 1'b0, 32'd0, 1'b0, 32'd0);
    chk1("credit_busy", busy, 1'b1);
    d0 = 1'b1; d0id = 32'd0;
    tick();
    d0 = 1'b0;
    chk_offer("credit_one_back", 1'b1, 32'd16, 1'b0, 32'd0);
    tick();
    chk_offer("credit_full_again", 1'b0, 32'd0, 1'b0, 32'd0);

    // Offer hold under backpressure, then simultaneous completions
    do_reset();
    start = 1'b1; num_rays = 32'd4; r0 = 1'b0; r1 = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_offer($sformatf("hold_c%0d", c), 1'b1, 32'd0, 1'b0, 32'd0);
      tick();
    end
    r0 = 1'b1;
    chk_offer("hold_accept", 1'b1, 32'd0, 1'b0, 32'd0);
    tick();
    chk_offer("hold_next_l1", 1'b0, 32'd0, 1'b1, 32'd1);
    tick();
    chk_offer("hold_id2", 1'b1, 32'd2, 1'b0, 32'd0);
    tick();
    chk_offer("hold_id3", 1'b0, 32'd0, 1'b1, 32'd3);
    tick();
    d0 = 1'b1; d0id = 32'd0; d0hit = 32'h3F80_0000;
    d1 = 1'b1; d1id = 32'd1; d1hit = 32'h4000_0000;
    tick();
    chk1("sim_rv0", rv0, 1'b1);
    chk32("sim_rid0", rid0, 32'd0);
    chk32("sim_rhit0", rhit0, 32'h3F80_0000);
    chk1("sim_rv1", rv1, 1'b1);
    chk32("sim_rid1", rid1, 32'd1);
    chk32("sim_rhit1", rhit1, 32'h4000_0000);
    d0id = 32'd2; d0hit = 32'h4040_0000;
    d1id = 32'd3; d1hit = 32'h4080_0000;
    tick();
    d0 = 1'b0; d1 = 1'b0;
    chk32("sim2_rid0", rid0, 32'd2);
    chk32("sim2_rhit1", rhit1, 32'h4080_0000);
    chk1("sim2_fin", fin, 1'b0);
    tick();
    chk1("sim_fin", fin, 1'b1);
    chk32("sim_cc", cc, 32'd12);
    chk1("sim_err", err, 1'b0);

    // Zero-ray frame from FINISH, then spurious done on an idle lane
    start = 1'b1; num_rays = 32'd0;
    tick();
    start = 1'b0;
    chk1("zero_fin", fin, 1'b1);
    chk1("zero_busy", busy, 1'b0);
    chk32("zero_cc", cc, 32'd0);
    chk_offer("zero_novalid", 1'b0, 32'd0, 1'b0, 32'd0);
    chk1("zero_err", err, 1'b0);
    d1 = 1'b1; d1id = 32'd5;
    tick();
    d1 = 1'b0;
    chk1("spur_err", err, 1'b1);
    start = 1'b1; num_rays = 32'd2; r0 = 1'b1; r1 = 1'b1;
    tick();
    start = 1'b0;
    chk_offer("spur_l0", 1'b1, 32'd0, 1'b0, 32'd0);
    tick();
    chk_offer("spur_l1_credit", 1'b0, 32'd0, 1'b1, 32'd1);
    chk1("spur_err_sticky", err, 1'b1);

    // Reset in the middle of a frame, then a fresh 2-ray frame
    tick();
    start = 1'b1; num_rays = 32'd6;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk1("abort_pre_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_fin", fin, 1'b0);
    chk1("abort_err", err, 1'b0);
    chk32("abort_cc", cc, 32'd0);
    chk_offer("abort_novalid", 1'b0, 32'd0, 1'b0, 32'd0);
    start = 1'b1; num_rays = 32'd2;
    tick();
    start = 1'b0;
    chk_offer("restart_id0", 1'b1, 32'd0, 1'b0, 32'd0);
    tick();
    chk_offer("restart_id1", 1'b0, 32'd0, 1'b1, 32'd1);
    tick();
    chk1("restart_fin_a", fin, 1'b0);
    d0 = 1'b1; d0id = 32'd0;
    tick();
    d0 = 1'b0;
    chk1("restart_fin_b", fin, 1'b0);
    d1 = 1'b1; d1id = 32'd1;
    tick();
    d1 = 1'b0;
    chk1("restart_fin_c", fin, 1'b0);
    tick();
    chk1("restart_fin", fin, 1'b1);
    chk32("restart_cc", cc, 32'd5);
    chk1("restart_err", err, 1'b0);

    // Randomized frames against the reference model
    do_reset();
    m_reset();
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(0, 30);
      cyc = 0;
      rand_cycle(1'b1, n);
      while (m_mode != 3 && cyc < 600) begin
        rand_cycle(1'b0, 32'd0);
        cyc++;
      end
      chk1($sformatf("rnd_frame%0d_finish", f), fin, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ray_dispatch_sched.md
Name: ray_dispatch_sched

Overview:
- Frame-level scheduler for the ray-tracing pipeline.
- On a start pulse it issues ray IDs 0..N-1 round-robin to two traversal lanes, one lane per stack manager.
- Each lane is flow-controlled by a per-lane in-flight credit limit.
- It counts completions, forwards per-lane hit results, and raises io_rtp_finish with a frame cycle count once every issued ray has retired.

Parameters:
- ID_W, 32, width of ray IDs and ray count.
- HIT_W, 32, width of the hitT result (FP32 bit pattern, passed through untouched).
- MAX_INFLIGHT, 8, maximum outstanding rays per lane (1..255).
- CNT_W, 32, width of the frame cycle counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- io_start  in  1  one-cycle pulse; begins a frame when idle
- io_num_rays  in  ID_W  rays in frame; sampled on accepted io_start
- io_busy  out  1  high from accepted start until finish
- io_lane0_valid  out  1  ray offered to lane 0
- io_lane0_ready  in  1  lane 0 accepts ray
- io_lane0_ray_id  out  ID_W  ray ID offered to lane 0
- io_lane1_valid / io_lane1_ready / io_lane1_ray_id  same as lane 0, for lane 1
- io_done0_valid  in  1  lane 0 retires one ray this cycle
- io_done0_ray_id  in  ID_W  retired ray ID
- io_done0_hitT  in  HIT_W  retired hit distance
- io_done1_valid / io_done1_ray_id / io_done1_hitT  same as lane 0, for lane 1
- io_res0_valid, io_res0_ray_id, io_res0_hitT  out  1/ID_W/HIT_W  registered copy of lane 0 done
- io_res1_valid, io_res1_ray_id, io_res1_hitT  out  same, registered copy of lane 1 done
- io_rtp_finish  out  1  frame complete (level)
- io_cycle_count  out  CNT_W  cycles from accepted start to finish
- io_err  out  1  sticky protocol error

Behaviour:
- Reset:
  - all outputs 0; FSM=IDLE
  - next_id=0, issued=0, retired=0
  - inflight0 = inflight1 = 0; rr pointer = lane 0
- FSM states: IDLE, DISPATCH, DRAIN, FINISH.
- IDLE:
  - io_start latches num_rays, clears counters and io_cycle_count, drops io_rtp_finish.
  - Next state is DISPATCH, or FINISH directly if num_rays==0.
- FINISH:
  - io_rtp_finish=1, io_busy=0; io_cycle_count frozen.
  - io_start is accepted exactly as in IDLE; FINISH behaves as IDLE plus a held finish flag.
- DISPATCH:
  - Eligible lane: inflight < MAX_INFLIGHT.
  - At most one ray is offered per cycle, on the rr-preferred eligible lane, else on the other eligible lane.
  - The offered lane has valid=1 and ray_id=next_id; the other lane has valid=0.
  - An offer, once made, holds the same lane and ID until ready. No re-arbitration while valid&&!ready.
  - On valid&&ready: next_id++, issued++, that lane's inflight++, rr points to the other lane.
  - When issued==num_rays after the handshake, next state is DRAIN.
- DRAIN: no valids; wait for retired==num_rays, then go to FINISH the next cycle.
- Retirement (any state):
  - doneK_valid decrements inflightK.
  - retired increments by popcount of the two done_valids (0, 1 or 2).
  - Issue and retire on the same lane in the same cycle leave inflight unchanged.
- Results: io_resK_* = doneK_* delayed exactly 1 cycle. valid=0 when no done. Both ports are independent, so no loss on simultaneous completions.
- io_cycle_count:
  - Increments every cycle while io_busy (DISPATCH or DRAIN).
  - Saturates at all-ones.
  - Holds its value in FINISH.
- io_err is set and held until reset on any of:
  - doneK_valid with inflightK==0; that counter does not underflow.
  - retired exceeding num_rays.
- io_start while busy is ignored.
- Reset mid-frame aborts: all state returns to reset values in the next cycle; lanes are not drained.
- Width: counters are ID_W bits; inflight counters are 8 bits.

Test Plan:
- num_rays=4, both readies held 1, done each ray 3 cycles after issue → IDs 0,2 on lane 0 and 1,3 on lane 1; one issue per cycle; io_rtp_finish rises; io_cycle_count=8; io_err=0.
- num_rays=20, MAX_INFLIGHT=8, no dones until cycle 30 → exactly 16 issued, both valids low. One done0 → one more issue on lane 0.
- lane0_ready held 0 for 5 cycles while offered ID 0 → valid and ID stable for 5 cycles, no switch to lane 1; lane 1 gets ID 1 after acceptance.
- done0 and done1 in the same cycle with hitT 0x3F800000 / 0x40000000 → both res ports valid next cycle with matching ID/hitT; retired += 2.
- num_rays=0 start → io_rtp_finish=1 next cycle, io_cycle_count=0, no valids. Spurious done1 with lane 1 idle → io_err=1, inflight1 stays 0.
- Reset asserted mid-DISPATCH, then start with num_rays=2 → IDs restart at 0, io_rtp_finish=0 until both rays retire.
